enigma_step_ctrl: RTL and testbench
===================================

Name: enigma_step_ctrl

Overview:
- Sequencer for the three-rotor Enigma datapath: indices 0 = right/fast, 1 = middle, 2 = left.
- Accepts commands over a valid/ready interface: per-rotor position load, zero-all, and encrypt-character.
- Generates per-rotor en/load/inc strobes, applying Enigma stepping rules from each rotor's turnover flag.
- Drives the right-side input mux, captures the reflected result and presents it on a valid/ready output.

Parameters:
- ALPHA, 26, alphabet size; positions and characters are 0..ALPHA-1.
- W, 5, width of position and character buses.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command; high only in IDLE.
- cmd_op  in  2  0=NOP, 1=LOAD, 2=ENCRYPT, 3=ZERO.
- cmd_rotor  in  2  rotor index for LOAD (0..2).
- cmd_data  in  W  position (LOAD) or plaintext character (ENCRYPT).
- rotor_en  out  3  per-rotor enable strobe.
- rotor_load  out  3  per-rotor load strobe.
- rotor_inc  out  3  per-rotor increment strobe.
- turnover_in  in  3  per-rotor is_at_turnover.
- in_sel  out  1  mux select for right rotor input: 1 = in_val, 0 = plugboard path.
- in_val  out  W  value driven into the datapath (load value or character).
- enc_result  in  W  combinational result returned by the datapath.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  W  registered ciphertext.
- err  out  1  sticky error flag; cleared by rst or by a ZERO command.

Behaviour:
- Reset: state=IDLE; all outputs 0 except cmd_ready=1. A reset mid-operation aborts immediately: out_valid drops and no strobe fires in the reset cycle.
- Handshake: a command is accepted at the edge where cmd_valid && cmd_ready. cmd_op, cmd_rotor and cmd_data are latched at that edge.
- NOP: accepted and discarded; remain in IDLE.
- States: IDLE, LOAD, STEP, EVAL, OUT.
- IDLE->LOAD on LOAD or ZERO.
- IDLE->STEP on ENCRYPT.
- LOAD->IDLE after 1 cycle.
- STEP->EVAL after 1 cycle.
- EVAL->OUT after 1 cycle.
- OUT->IDLE on out_ready.
- LOAD state: in_sel=1, in_val=latched data; rotor_en[i] and rotor_load[i] are asserted for the selected rotor only, for one cycle.
- LOAD error: if cmd_rotor==3 or data>=ALPHA, no strobe fires and err sets; the one-cycle LOAD state is still taken.
- ZERO: in_val=0 and all three rotors receive en+load in the same cycle; err clears.
- STEP state: one cycle. All three rotor_en are high. Increments are decided from the turnover_in values sampled in that cycle (pre-step):
  - inc[0]=1 always.
  - inc[1]=turnover_in[0] | turnover_in[1] (double step).
  - inc[2]=turnover_in[1].
  All rotors update at the same edge. Wrap 25->0 is handled inside the rotor.
- EVAL state: in_sel=1, in_val=latched character, no strobes. enc_result is registered into out_data at the end of EVAL.
- ENCRYPT error: character >=ALPHA sets err; the sequence still runs and out_data is undefined.
- OUT state: out_valid=1; out_data is held stable until out_ready. At the edge where out_valid && out_ready, go to IDLE.
- Latency: out_valid rises 3 edges after the accept edge. Best-case throughput is one character per 4 cycles.
- cmd_ready=0 in every non-IDLE state; commands wait and are not dropped.
- rotor_load and rotor_inc are never high together for one rotor. No rotor strobes occur outside LOAD and STEP.

Optional Feature:
- ENIGMA_DOUBLE_STEP_EN defined: stepping equations exactly as above (historical double-step anomaly).
- Undefined: pure odometer stepping:
  - inc[1]=turnover_in[0].
  - inc[2]=turnover_in[0] & turnover_in[1].
  - A middle rotor sitting at turnover does not step itself.

Decomposition:
- Shared package enigma_pkg: ALPHA, W, cmd_op encodings (OP_NOP/OP_LOAD/OP_ENCRYPT/OP_ZERO), rotor index constants (ROT_R/ROT_M/ROT_L), state enum.
- Sub-module enigma_step_logic: combinational turnover[2:0] -> inc[2:0], holding the ENIGMA_DOUBLE_STEP_EN variants. The FSM stays in enigma_step_ctrl.

Test Plan (bench uses three rotor models, turnover at position 16):
- rst high mid-EVAL -> next cycle: state IDLE, out_valid=0, rotor_* =0, cmd_ready=1.
- LOAD rotor 1 data 7 -> exactly one cycle with rotor_en=3'b010, rotor_load=3'b010, in_val=7; cmd_ready back high on the following cycle.
- LOAD data 26 -> no strobe, err=1; subsequent ZERO -> all rotor_load=3'b111 with in_val=0, err=0.
- Positions L=0, M=0, R=15; ENCRYPT 'A'(0) twice:
  - First: rotor_inc=3'b001, result R=16.
  - Second: rotor_inc=3'b011, result R=17, M=1.
  - out_valid rises 3 edges after each accept.
- Double step, positions L=0, M=15, R=16 with ENIGMA_DOUBLE_STEP_EN:
  - First ENCRYPT -> inc=3'b011, result R=17, M=16.
  - Second ENCRYPT -> inc=3'b110|3'b001, result R=18, M=17, L=1.
  - Without the macro, the second encrypt gives inc=3'b001, result R=18, M=16, L=0.
- Output backpressure: out_ready low for 5 cycles -> out_valid and out_data held constant, cmd_ready=0, new cmd_valid not accepted; accept occurs 1 cycle after out_ready handshake.

Source files
------------

// File: rtl/enigma_pkg.sv
// Shared constants, command encodings and FSM state type for the Enigma step controller.
// Build option ENIGMA_DOUBLE_STEP_EN (used by enigma_step_logic) selects historical stepping.
package enigma_pkg;

    localparam int unsigned ALPHA      = 26;
    localparam int unsigned W          = 5;
    localparam int unsigned NUM_ROTORS = 3;

    localparam logic [W-1:0] LAST_POS = W'(ALPHA - 1);

    localparam logic [1:0] OP_NOP     = 2'd0;
    localparam logic [1:0] OP_LOAD    = 2'd1;
    localparam logic [1:0] OP_ENCRYPT = 2'd2;
    localparam logic [1:0] OP_ZERO    = 2'd3;

    localparam logic [1:0] ROT_R = 2'd0;
    localparam logic [1:0] ROT_M = 2'd1;
    localparam logic [1:0] ROT_L = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStep,
        StEval,
        StOut
    } state_e;

    function automatic logic char_ok(input logic [W-1:0] value);
        return value <= LAST_POS;
    endfunction

    function automatic logic load_ok(input logic [1:0] rotor, input logic [W-1:0] value);
        return (rotor <= ROT_L) && char_ok(value);
    endfunction

    function automatic logic [NUM_ROTORS-1:0] rotor_onehot(input logic [1:0] rotor);
        logic [NUM_ROTORS-1:0] oh;
        oh = '0;
        case (rotor)
            ROT_R:   oh[0] = 1'b1;
            ROT_M:   oh[1] = 1'b1;
            ROT_L:   oh[2] = 1'b1;
            default: oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/enigma_step_logic.sv
// Rotor increment decision from the pre-step turnover flags.
// ENIGMA_DOUBLE_STEP_EN defined: historical double step; undefined: plain odometer carry.
module enigma_step_logic
    import enigma_pkg::*;
(
    input  logic [NUM_ROTORS-1:0] turnover_i,
    output logic [NUM_ROTORS-1:0] inc_o
);

    always_comb begin
        inc_o        = '0;
        inc_o[ROT_R] = 1'b1;
`ifdef ENIGMA_DOUBLE_STEP_EN
        // A middle rotor at its own notch steps again, dragging the left rotor with it.
        inc_o[ROT_M] = turnover_i[ROT_R] | turnover_i[ROT_M];
        inc_o[ROT_L] = turnover_i[ROT_M];
`else
        inc_o[ROT_M] = turnover_i[ROT_R];
        inc_o[ROT_L] = turnover_i[ROT_R] & turnover_i[ROT_M];
`endif
    end

endmodule

// File: rtl/enigma_step_ctrl.sv
// Command sequencer for the three-rotor Enigma datapath: load/zero/encrypt with stepping.
// Stepping variant chosen in enigma_step_logic by ENIGMA_DOUBLE_STEP_EN.
module enigma_step_ctrl
    import enigma_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [1:0]            cmd_rotor,
    input  logic [W-1:0]          cmd_data,
    output logic [NUM_ROTORS-1:0] rotor_en,
    output logic [NUM_ROTORS-1:0] rotor_load,
    output logic [NUM_ROTORS-1:0] rotor_inc,
    input  logic [NUM_ROTORS-1:0] turnover_in,
    output logic                  in_sel,
    output logic [W-1:0]          in_val,
    input  logic [W-1:0]          enc_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W-1:0]          out_data,
    output logic                  err
);

    state_e                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [1:0]            rotor_q, rotor_d;
    logic [W-1:0]          data_q, data_d;
    logic [W-1:0]          out_data_q, out_data_d;
    logic                  err_q, err_d;
    logic [NUM_ROTORS-1:0] step_inc;

    enigma_step_logic u_step_logic (
        .turnover_i (turnover_in),
        .inc_o      (step_inc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            op_q       <= OP_NOP;
            rotor_q    <= ROT_R;
            data_q     <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rotor_q    <= rotor_d;
            data_q     <= data_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        rotor_d    = rotor_q;
        data_d     = data_q;
        out_data_d = out_data_q;
        err_d      = err_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    rotor_d = cmd_rotor;
                    data_d  = cmd_data;
                    // Error flag is decided at accept time from the incoming command.
                    case (cmd_op)
                        OP_NOP: state_d = StIdle;
                        OP_LOAD: begin
                            state_d = StLoad;
                            if (!load_ok(cmd_rotor, cmd_data)) begin
                                err_d = 1'b1;
                            end
                        end
                        OP_ENCRYPT: begin
                            state_d = StStep;
                            if (!char_ok(cmd_data)) begin
                                err_d = 1'b1;
                            end
                        end
                        OP_ZERO: begin
                            state_d = StLoad;
                            err_d   = 1'b0;
                        end
                    endcase
                end
            end
            StLoad: state_d = StIdle;
            StStep: state_d = StEval;
            StEval: begin
                out_data_d = enc_result;
                state_d    = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cmd_ready  = (state_q == StIdle);
        rotor_en   = '0;
        rotor_load = '0;
        rotor_inc  = '0;
        in_sel     = 1'b0;
        in_val     = '0;
        out_valid  = 1'b0;
        unique case (state_q)
            StLoad: begin
                in_sel = 1'b1;
                if (op_q == OP_ZERO) begin
                    rotor_en   = '1;
                    rotor_load = '1;
                end else begin
                    in_val = data_q;
                    if (load_ok(rotor_q, data_q)) begin
                        rotor_en   = rotor_onehot(rotor_q);
                        rotor_load = rotor_onehot(rotor_q);
                    end
                end
            end
            StStep: begin
                rotor_en  = '1;
                rotor_inc = step_inc;
            end
            StEval: begin
                in_sel = 1'b1;
                in_val = data_q;
            end
            StOut:   out_valid = 1'b1;
            default: ;
        endcase
        // Reset aborts at once: nothing may strobe the rotors in the reset cycle itself.
        if (rst) begin
            rotor_en   = '0;
            rotor_load = '0;
            rotor_inc  = '0;
            in_sel     = 1'b0;
            in_val     = '0;
            out_valid  = 1'b0;
        end
    end

    assign out_data = out_data_q;
    assign err      = err_q;

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed bench for enigma_step_ctrl with three rotor models (notch at 16) and a command-level
// model; ENIGMA_DOUBLE_STEP_EN selects which stepping expectations apply.
module tb_enigma_step_ctrl;
    import enigma_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [1:0] cmd_rotor = 2'd0;
    logic [4:0] cmd_data = 5'd0;
    logic [2:0] rotor_en, rotor_load, rotor_inc, turnover_in;
    logic       in_sel;
    logic [4:0] in_val, enc_result;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] out_data;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    enigma_step_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rotor   (cmd_rotor),
        .cmd_data    (cmd_data),
        .rotor_en    (rotor_en),
        .rotor_load  (rotor_load),
        .rotor_inc   (rotor_inc),
        .turnover_in (turnover_in),
        .in_sel      (in_sel),
        .in_val      (in_val),
        .enc_result  (enc_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Stand-in datapath: any position-dependent function will do.
    function automatic logic [4:0] cipher(input logic [4:0] c, input int p0, input int p1,
                                          input int p2);
        int s;
        s = int'(c) + p0 + 2 * p1 + 3 * p2 + 7;
        return 5'(s % 26);
    endfunction

    // Rotor models driven by the DUT strobes.
    int pos [3] = '{0, 0, 0};
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rotor_en[i]) begin
                if (rotor_load[i]) pos[i] <= int'(in_val);
                else if (rotor_inc[i]) pos[i] <= (pos[i] + 1) % 26;
            end
        end
    end
    assign turnover_in = {pos[2] == 16, pos[1] == 16, pos[0] == 16};
    assign enc_result  = cipher(in_val, pos[0], pos[1], pos[2]);

    // Command-level model: positions, error flag and expected ciphertexts.
    int         m_pos [3] = '{0, 0, 0};
    bit         m_known = 1'b0;
    bit         m_err = 1'b0;
    logic [2:0] m_inc = 3'd0;
    int         exp_q [$];

    function automatic logic [2:0] model_inc(input int r, input int m);
        bit tr;
        bit tm;
        tr = (r == 16);
        tm = (m == 16);
`ifdef ENIGMA_DOUBLE_STEP_EN
        return {tm, tr | tm, 1'b1};
`else
        return {tr & tm, tr, 1'b1};
`endif
    endfunction

    task automatic model_accept(input logic [1:0] op, input logic [1:0] rot, input logic [4:0] d);
        case (op)
            2'd1: begin
                if (int'(rot) <= 2 && int'(d) < 26) m_pos[int'(rot)] = int'(d);
                else m_err = 1'b1;
            end
            2'd3: begin
                m_pos   = '{0, 0, 0};
                m_known = 1'b1;
                m_err   = 1'b0;
            end
            2'd2: begin
                m_inc = model_inc(m_pos[0], m_pos[1]);
                for (int i = 0; i < 3; i++) begin
                    if (m_inc[i]) m_pos[i] = (m_pos[i] + 1) % 26;
                end
                if (int'(d) >= 26) begin
                    m_err = 1'b1;
                    exp_q.push_back(-1);
                end else begin
                    exp_q.push_back(m_known ? int'(cipher(d, m_pos[0], m_pos[1], m_pos[2])) : -1);
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_err   = 1'b0;
            m_known = 1'b0;
        end else begin
            if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (cmd_valid && cmd_ready) model_accept(cmd_op, cmd_rotor, cmd_data);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            check("load_inc_excl", 32'(rotor_load & rotor_inc), 0);
            if (rotor_inc != 3'd0) begin
                check("step_en", 32'(rotor_en), 7);
                check("step_inc", 32'(rotor_inc), 32'(m_inc));
            end
            if (out_valid) begin
                check("out_pending", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0 && exp_q[0] >= 0) check("out_data", 32'(out_data), exp_q[0]);
            end
            if (cmd_ready) begin
                check("idle_err", 32'(err), 32'(m_err));
                check("idle_quiet", 32'({out_valid, rotor_en, rotor_load, rotor_inc}), 0);
                if (m_known) begin
                    for (int i = 0; i < 3; i++) check("idle_pos", pos[i], m_pos[i]);
                end
            end
        end
    end

    // Called at a falling edge; returns at the falling edge just after the accept edge.
    task automatic send(input logic [1:0] op, input logic [1:0] rot, input logic [4:0] d);
        int waited;
        waited    = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rotor = rot;
        cmd_data  = d;
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("accept_within_bound", 32'(cmd_ready), 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic finish_enc(input string tag, input int exp_data);
        int edges;
        edges = 1;
        while (!out_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_latency"}, edges, 3);
        if (exp_data >= 0) check({tag, "_data"}, 32'(out_data), exp_data);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_ready_after"}, 32'(cmd_ready), 1);
    endtask

    task automatic encrypt(input string tag, input logic [4:0] c, input logic [2:0] exp_inc,
                           input int r, input int m, input int l, input int exp_data);
        send(OP_ENCRYPT, ROT_R, c);
        check({tag, "_inc"}, 32'(rotor_inc), 32'(exp_inc));
        finish_enc(tag, exp_data);
        check({tag, "_pos_r"}, pos[0], r);
        check({tag, "_pos_m"}, pos[1], m);
        check({tag, "_pos_l"}, pos[2], l);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t, expected the run to have finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] held;

        repeat (3) @(negedge clk);
        check("rst_hold_ready", 32'(cmd_ready), 1);
        check("rst_hold_en", 32'(rotor_en), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 1);
        check("rst_valid", 32'(out_valid), 0);
        check("rst_err", 32'(err), 0);
        check("rst_strobes", 32'({rotor_en, rotor_load, rotor_inc}), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_in_sel", 32'(in_sel), 0);

        send(OP_ZERO, ROT_R, 5'd0);
        check("zero0_load", 32'(rotor_load), 7);
        @(negedge clk);

        send(OP_LOAD, ROT_M, 5'd7);
        check("ld7_en", 32'(rotor_en), 2);
        check("ld7_load", 32'(rotor_load), 2);
        check("ld7_in_val", 32'(in_val), 7);
        check("ld7_in_sel", 32'(in_sel), 1);
        check("ld7_busy", 32'(cmd_ready), 0);
        @(negedge clk);
        check("ld7_done_en", 32'(rotor_en), 0);
        check("ld7_done_ready", 32'(cmd_ready), 1);
        check("ld7_pos", pos[1], 7);

        send(OP_LOAD, ROT_R, 5'd26);
        check("ld26_en", 32'(rotor_en), 0);
        check("ld26_load", 32'(rotor_load), 0);
        @(negedge clk);
        check("ld26_err", 32'(err), 1);
        send(OP_LOAD, 2'd3, 5'd4);
        check("ldr3_en", 32'(rotor_en), 0);
        @(negedge clk);
        check("ldr3_err", 32'(err), 1);

        send(OP_ZERO, ROT_R, 5'd9);
        check("zero_en", 32'(rotor_en), 7);
        check("zero_load", 32'(rotor_load), 7);
        check("zero_in_val", 32'(in_val), 0);
        @(negedge clk);
        check("zero_err", 32'(err), 0);
        check("zero_pos_m", pos[1], 0);

        send(OP_NOP, ROT_R, 5'd0);
        check("nop_ready", 32'(cmd_ready), 1);
        check("nop_en", 32'(rotor_en), 0);

        send(OP_LOAD, ROT_R, 5'd15);
        @(negedge clk);
        encrypt("enc1", 5'd0, 3'b001, 16, 0, 0, 23);
        encrypt("enc2", 5'd0, 3'b011, 17, 1, 0, 0);

        send(OP_ZERO, ROT_R, 5'd0);
        @(negedge clk);
        send(OP_LOAD, ROT_M, 5'd15);
        @(negedge clk);
        send(OP_LOAD, ROT_R, 5'd16);
        @(negedge clk);
        encrypt("ds1", 5'd0, 3'b011, 17, 16, 0, 4);
`ifdef ENIGMA_DOUBLE_STEP_EN
        encrypt("ds2", 5'd0, 3'b111, 18, 17, 1, 10);
`else
        encrypt("ds2", 5'd0, 3'b001, 18, 16, 0, 5);
`endif

        // Backpressure with a command waiting.
        send(OP_ENCRYPT, ROT_R, 5'd3);
        repeat (2) @(negedge clk);
        check("bp_valid", 32'(out_valid), 1);
        held      = out_data;
        cmd_valid = 1'b1;
        cmd_op    = OP_LOAD;
        cmd_rotor = ROT_L;
        cmd_data  = 5'd9;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", 32'(out_valid), 1);
            check("bp_hold_data", 32'(out_data), 32'(held));
            check("bp_hold_busy", 32'(cmd_ready), 0);
            @(negedge clk);
        end
        check("bp_no_accept", 32'(pos[2] == 9), 0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle_ready", 32'(cmd_ready), 1);
        check("bp_idle_valid", 32'(out_valid), 0);
        @(negedge clk);
        check("bp_load_after", 32'(rotor_load), 4);
        check("bp_load_val", 32'(in_val), 9);
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        @(negedge clk);
        check("bp_pos_l", pos[2], 9);

        // Out-of-range character still runs the sequence.
        send(OP_ENCRYPT, ROT_R, 5'd30);
        finish_enc("badc", -1);
        check("badc_err", 32'(err), 1);
        send(OP_ZERO, ROT_R, 5'd0);
        @(negedge clk);
        check("badc_cleared", 32'(err), 0);

        // Reset during EVAL.
        send(OP_ENCRYPT, ROT_R, 5'd5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rsteval_valid", 32'(out_valid), 0);
        check("rsteval_strobes", 32'({rotor_en, rotor_load, rotor_inc}), 0);
        @(negedge clk);
        check("rsteval_ready", 32'(cmd_ready), 1);
        check("rsteval_out_valid", 32'(out_valid), 0);
        check("rsteval_quiet", 32'({rotor_en, rotor_load, rotor_inc}), 0);
        rst = 1'b0;
        @(negedge clk);
        check("rsteval_stays_idle", 32'(out_valid), 0);
        check("rsteval_idle_ready", 32'(cmd_ready), 1);

        // Reset during STEP: no increment may reach the rotors.
        send(OP_ZERO, ROT_R, 5'd0);
        @(negedge clk);
        send(OP_ENCRYPT, ROT_R, 5'd1);
        check("rststep_pre_en", 32'(rotor_en), 7);
        rst = 1'b1;
        #1;
        check("rststep_en", 32'(rotor_en), 0);
        check("rststep_inc", 32'(rotor_inc), 0);
        @(negedge clk);
        rst = 1'b0;
        check("rststep_pos_r", pos[0], 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
